// File: rtl/imm_gen_pipe.sv
// rtl/imm_gen_pipe.sv - registered RISC-V immediate generator with valid/ready and optional skid entry
//
// Purpose: decodes the immediate of a 32-bit RISC-V instruction (I/S/B/U/J, shift
// amount, CSR uimm) for RV32 or RV64, flags unsupported opcodes, and registers the
// result with a valid/ready handshake at one instruction per clock.
//
// Parameters: XLEN (32/64), TAG_W (side-band tag width), SKID (1: 2-entry skid, 0: single stage)
//
// Ports:
//   clk, rst                      clock (rising edge), asynchronous active-high reset
//   in_valid, in_ready            input handshake
//   in_inst[31:0], in_tag         instruction word and its side-band tag
//   out_valid, out_ready          output handshake
//   out_imm[XLEN-1:0]             immediate, extended to XLEN
//   out_fmt[2:0]                  0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J, 6 SHAMT, 7 CSR-UIMM
//   out_illegal                   unsupported opcode (out_imm=0, out_fmt=0)
//   out_tag                       tag travelling with the instruction
//
// Build option: IMMGEN_ERRCNT_EN adds err_count[15:0] (out) and err_clr (in), a
// saturating count of accepted instructions decoded illegal.
module imm_gen_pipe #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 32,
    parameter int SKID  = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_inst,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [2:0]       out_fmt,
    output logic             out_illegal,
    output logic [TAG_W-1:0] out_tag
`ifdef IMMGEN_ERRCNT_EN
    ,
    output logic [15:0]      err_count,
    input  logic             err_clr
`endif
);

    localparam logic [2:0] FMT_NONE  = 3'd0;
    localparam logic [2:0] FMT_I     = 3'd1;
    localparam logic [2:0] FMT_S     = 3'd2;
    localparam logic [2:0] FMT_B     = 3'd3;
    localparam logic [2:0] FMT_U     = 3'd4;
    localparam logic [2:0] FMT_J     = 3'd5;
    localparam logic [2:0] FMT_SHAMT = 3'd6;
    localparam logic [2:0] FMT_CSR   = 3'd7;

    // Packed pipeline word: {illegal, fmt, imm, tag}
    localparam int PW = 1 + 3 + XLEN + TAG_W;

    logic [31:0]     dec_imm32;
    logic [2:0]      dec_fmt;
    logic            dec_illegal;
    logic [XLEN-1:0] dec_imm;
    logic [PW-1:0]   dec_word;
    logic [PW-1:0]   out_word;
    logic            accept;

    // Every format fits in 32 bits with inst[31] as its sign, so the decode builds a
    // 32-bit value and a single signed widening covers RV64. Zero-extended formats
    // keep bit 31 clear and so widen to zero.
    always_comb begin
        dec_imm32   = '0;
        dec_fmt     = FMT_NONE;
        dec_illegal = 1'b0;
        case (in_inst[6:0])
            7'b0110111, 7'b0010111: begin
                dec_fmt   = FMT_U;
                dec_imm32 = {in_inst[31:12], 12'b0};
            end
            7'b1101111: begin
                dec_fmt   = FMT_J;
                dec_imm32 = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12],
                             in_inst[20], in_inst[30:21], 1'b0};
            end
            7'b1100111, 7'b0000011: begin
                dec_fmt   = FMT_I;
                dec_imm32 = {{20{in_inst[31]}}, in_inst[31:20]};
            end
            7'b0100011: begin
                dec_fmt   = FMT_S;
                dec_imm32 = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
            end
            7'b1100011: begin
                dec_fmt   = FMT_B;
                dec_imm32 = {{19{in_inst[31]}}, in_inst[31], in_inst[7],
                             in_inst[30:25], in_inst[11:8], 1'b0};
            end
            7'b0010011: begin
                // funct3 001 (SLLI) and 101 (SRLI/SRAI) share low bits 01
                if (in_inst[13:12] == 2'b01) begin
                    dec_fmt = FMT_SHAMT;
                    if (XLEN == 64) dec_imm32 = {26'b0, in_inst[25:20]};
                    else            dec_imm32 = {27'b0, in_inst[24:20]};
                end else begin
                    dec_fmt   = FMT_I;
                    dec_imm32 = {{20{in_inst[31]}}, in_inst[31:20]};
                end
            end
            7'b0011011: begin
                if (XLEN != 64) begin
                    dec_illegal = 1'b1;
                end else if (in_inst[13:12] == 2'b01) begin
                    dec_fmt   = FMT_SHAMT;
                    dec_imm32 = {27'b0, in_inst[24:20]};
                end else begin
                    dec_fmt   = FMT_I;
                    dec_imm32 = {{20{in_inst[31]}}, in_inst[31:20]};
                end
            end
            7'b1110011: begin
                if (in_inst[14]) begin
                    dec_fmt   = FMT_CSR;
                    dec_imm32 = {27'b0, in_inst[19:15]};
                end else begin
                    dec_fmt   = FMT_I;
                    dec_imm32 = {{20{in_inst[31]}}, in_inst[31:20]};
                end
            end
            7'b0110011, 7'b0001111: begin
                dec_fmt = FMT_NONE;
            end
            7'b0111011: begin
                dec_illegal = (XLEN != 64);
            end
            default: begin
                dec_illegal = 1'b1;
            end
        endcase
        // Compressed encodings are not handled by this block
        if (in_inst[1:0] != 2'b11) dec_illegal = 1'b1;
        if (dec_illegal) begin
            dec_imm32 = '0;
            dec_fmt   = FMT_NONE;
        end
    end

    assign dec_imm  = XLEN'($signed(dec_imm32));
    assign dec_word = {dec_illegal, dec_fmt, dec_imm, in_tag};
    assign accept   = in_valid & in_ready;

    assign {out_illegal, out_fmt, out_imm, out_tag} = out_word;

    generate
        if (SKID != 0) begin : g_skid
            logic          skid_valid;
            logic [PW-1:0] skid_word;

            // skid_valid is a flop, so in_ready carries no path from out_ready
            assign in_ready = !rst && !skid_valid;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    out_valid  <= 1'b0;
                    out_word   <= '0;
                    skid_valid <= 1'b0;
                    skid_word  <= '0;
                end else if (!out_valid || out_ready) begin
                    // Output free this edge: the older skid entry goes first.
                    // in_ready is low whenever the skid holds data, so no input
                    // can arrive in that case.
                    if (skid_valid) begin
                        out_word   <= skid_word;
                        out_valid  <= 1'b1;
                        skid_valid <= 1'b0;
                    end else begin
                        out_valid <= accept;
                        if (accept) out_word <= dec_word;
                    end
                end else if (accept) begin
                    skid_valid <= 1'b1;
                    skid_word  <= dec_word;
                end
            end
        end else begin : g_noskid
            assign in_ready = !rst && (!out_valid || out_ready);

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    out_valid <= 1'b0;
                    out_word  <= '0;
                end else if (!out_valid || out_ready) begin
                    out_valid <= accept;
                    if (accept) out_word <= dec_word;
                end
            end
        end
    endgenerate

`ifdef IMMGEN_ERRCNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_count <= '0;
        end else if (err_clr) begin
            err_count <= '0;
        end else if (accept && dec_illegal && (err_count != 16'hFFFF)) begin
            err_count <= err_count + 16'd1;
        end
    end
`endif

endmodule
